instr_fetch_queue: RTL and testbench

- Sits directly downstream of the decompressor buffer (topBuffer) and upstream of the CPU fetch port.
- Drives the PC into the decompressor and captures each decompressed instruction after a fixed latency.
- Queues instruction/PC pairs in a small FIFO and hands them to the CPU with a valid/ready handshake.
- A CPU redirect (branch/exception) flushes the queue and all in-flight requests.

---
 rtl/instr_fetch_queue.sv | 199 +++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC generator and instruction queue between the
// decompressor (topBuffer) and the CPU fetch port.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   decomp_pc_o           - PC presented to the decompressor (registered)
//   decomp_instr_i        - decompressed instruction, DECOMP_LAT cycles after its PC
//   redirect_i/_pc_i      - CPU fetch restart request and target
//   instr_valid_o/_o/_pc_o- head of the instruction queue
//   instr_ready_i         - CPU accepts the head entry
//   fetch_done_o          - PC_LIMIT fetched, no redirect since
//
// Optional: define IFQ_PERF_CNT_EN to add perf_delivered_o, perf_stall_o and
// perf_flush_o saturating 32-bit event counters.
module instr_fetch_queue #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH      = 4,
    parameter int unsigned      DECOMP_LAT = 1,
    parameter int unsigned      PC_STEP    = 4,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter logic [WIDTH-1:0] PC_LIMIT   = 'h1BC
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] decomp_pc_o,
    input  logic [WIDTH-1:0] decomp_instr_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             instr_valid_o,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] instr_pc_o,
    input  logic             instr_ready_i,
    output logic             fetch_done_o
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]      perf_delivered_o,
    output logic [31:0]      perf_stall_o,
    output logic [31:0]      perf_flush_o
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = $clog2(DEPTH + DECOMP_LAT + 1) + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             done_q, done_d;
    logic [DECOMP_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [WIDTH-1:0] tag_pc_q [DECOMP_LAT];
    logic [WIDTH-1:0] tag_pc_d [DECOMP_LAT];
    logic [WIDTH-1:0] fifo_instr_q [DEPTH];
    logic [WIDTH-1:0] fifo_instr_d [DEPTH];
    logic [WIDTH-1:0] fifo_pc_q [DEPTH];
    logic [WIDTH-1:0] fifo_pc_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] instr_q, instr_d, ipc_q, ipc_d;

    logic [SUM_W-1:0] inflight;
    logic             issue, push, pop;

    // Issue credit, pipe shift, FIFO update; redirect overrides everything.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(DECOMP_LAT); i++) begin
            inflight = inflight + SUM_W'(tag_vld_q[i]);
        end
        issue = ((SUM_W'(count_q) + inflight) < SUM_W'(DEPTH)) && !done_q && !redirect_i;
        push  = tag_vld_q[DECOMP_LAT-1] && !redirect_i;
        pop   = valid_q && instr_ready_i && !redirect_i;

        pc_d         = pc_q;
        done_d       = done_q;
        tag_vld_d    = tag_vld_q;
        tag_pc_d     = tag_pc_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;

        if (redirect_i) begin
            pc_d      = redirect_pc_i;
            done_d    = 1'b0;
            tag_vld_d = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (issue) begin
                // The last sequential address is fetched once; PC then parks on it.
                if (pc_q == PC_LIMIT) begin
                    done_d = 1'b1;
                end else begin
                    pc_d = pc_q + WIDTH'(PC_STEP);
                end
            end
            for (int i = int'(DECOMP_LAT) - 1; i > 0; i--) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_pc_d[i]  = tag_pc_q[i-1];
            end
            tag_vld_d[0] = issue;
            tag_pc_d[0]  = pc_q;
            if (push) begin
                fifo_instr_d[wr_ptr_q] = decomp_instr_i;
                fifo_pc_d[wr_ptr_q]    = tag_pc_q[DECOMP_LAT-1];
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // Head outputs are registered from the next-state FIFO view.
        valid_d = (count_d != '0);
        instr_d = fifo_instr_d[rd_ptr_d];
        ipc_d   = fifo_pc_d[rd_ptr_d];
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            done_q    <= 1'b0;
            tag_vld_q <= '0;
            for (int i = 0; i < int'(DECOMP_LAT); i++) begin
                tag_pc_q[i] <= '0;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            ipc_q     <= '0;
        end else begin
            pc_q         <= pc_d;
            done_q       <= done_d;
            tag_vld_q    <= tag_vld_d;
            tag_pc_q     <= tag_pc_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            ipc_q        <= ipc_d;
        end
    end

    assign decomp_pc_o   = pc_q;
    assign fetch_done_o  = done_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] perf_del_q, perf_del_d, perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

    // Saturating event counters.
    always_comb begin
        perf_del_d   = perf_del_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (valid_q && instr_ready_i && perf_del_q != 32'hFFFF_FFFF) begin
            perf_del_d = perf_del_q + 32'd1;
        end
        if (!valid_q && !done_q && perf_stall_q != 32'hFFFF_FFFF) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redirect_i && perf_flush_q != 32'hFFFF_FFFF) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_del_q   <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_del_q   <= perf_del_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_delivered_o = perf_del_q;
    assign perf_stall_o     = perf_stall_q;
    assign perf_flush_o     = perf_flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (default parameters, DECOMP_LAT=1).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] decomp_pc_o;
    logic [31:0] decomp_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        fetch_done_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instr_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .decomp_pc_o    (decomp_pc_o),
        .decomp_instr_i (decomp_instr_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .instr_valid_o  (instr_valid_o),
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
        .instr_ready_i  (instr_ready_i),
        .fetch_done_o   (fetch_done_o)
    );

    // Decompressor contents: distinct word per PC, fixed word at the limit.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        if (pc == 32'h1BC) return 32'h1EFF_2FE1;
        return {8'hA5, pc[23:0]} ^ 32'h0000_5A00;
    endfunction

    // One-cycle decompressor model.
    always @(posedge clk) decomp_instr_i <= instr_of(decomp_pc_o);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset         = 1'b1;
        instr_ready_i = rdy;
        redirect_i    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] exp_pc;
    logic [23:0] pat;

    initial begin
        reset          = 1'b1;
        instr_ready_i  = 1'b0;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_pc",    decomp_pc_o, 32'h0);
        chk("rst_valid", 32'(instr_valid_o), 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_ipc",   instr_pc_o, 32'h0);
        chk("rst_done",  32'(fetch_done_o), 32'h0);

        // Streaming to PC_LIMIT with ready held high
        do_reset(1'b1);
        @(negedge clk);
        chk("lat_valid0", 32'(instr_valid_o), 32'h0);
        chk("lat_pc",     decomp_pc_o, 32'h4);
        for (int k = 0; k <= 111; k++) begin
            @(negedge clk);
            chk("seq_valid", 32'(instr_valid_o), 32'h1);
            chk("seq_pc",    instr_pc_o, 32'(k * 4));
            chk("seq_instr", instr_o, instr_of(32'(k * 4)));
        end
        chk("lim_done", 32'(fetch_done_o), 32'h1);
        chk("lim_dpc",  decomp_pc_o, 32'h1BC);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_valid", 32'(instr_valid_o), 32'h0);
            chk("post_done",  32'(fetch_done_o), 32'h1);
            chk("post_dpc",   decomp_pc_o, 32'h1BC);
        end

        // Backpressure from the start: queue fills to DEPTH, then drains seamlessly
        do_reset(1'b0);
        repeat (8) @(negedge clk);
        chk("full_dpc",   decomp_pc_o, 32'h10);
        chk("full_valid", 32'(instr_valid_o), 32'h1);
        chk("full_head",  instr_pc_o, 32'h0);
        instr_ready_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("drain_valid", 32'(instr_valid_o), 32'h1);
            chk("drain_pc",    instr_pc_o, 32'(k * 4));
            chk("drain_instr", instr_o, instr_of(32'(k * 4)));
        end

        // Redirect with 3 queued and PC 0x10 in flight
        do_reset(1'b0);
        repeat (8) @(negedge clk);
        chk("rd_head0", instr_pc_o, 32'h0);
        instr_ready_i = 1'b1;
        @(negedge clk);
        chk("rd_head4", instr_pc_o, 32'h4);
        instr_ready_i = 1'b0;
        @(negedge clk);
        chk("rd_dpc14", decomp_pc_o, 32'h14);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        @(negedge clk);
        chk("rd_flush_valid", 32'(instr_valid_o), 32'h0);
        chk("rd_flush_dpc",   decomp_pc_o, 32'h100);
        chk("rd_flush_done",  32'(fetch_done_o), 32'h0);
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;
        @(negedge clk);
        chk("rd_gap_valid", 32'(instr_valid_o), 32'h0);
        chk("rd_gap_dpc",   decomp_pc_o, 32'h104);
        @(negedge clk);
        chk("rd_first_valid", 32'(instr_valid_o), 32'h1);
        chk("rd_first_pc",    instr_pc_o, 32'h100);
        chk("rd_first_instr", instr_o, instr_of(32'h100));

        // Mixed push/pop with an irregular ready pattern; order must hold
        exp_pc = 32'h104;
        pat    = 24'b1011_0010_1110_0110_1101_0011;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (instr_valid_o) begin
                chk("mix_pc",    instr_pc_o, exp_pc);
                chk("mix_instr", instr_o, instr_of(exp_pc));
            end
            instr_ready_i = pat[i];
            if (instr_valid_o && pat[i]) exp_pc = exp_pc + 32'h4;
        end
        chk("mix_progress", 32'(exp_pc > 32'h120), 32'h1);

        // Asynchronous reset between clock edges
        instr_ready_i = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 32'(instr_valid_o), 32'h0);
        chk("async_dpc",   decomp_pc_o, 32'h0);
        chk("async_ipc",   instr_pc_o, 32'h0);
        chk("async_done",  32'(fetch_done_o), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("restart_valid0", 32'(instr_valid_o), 32'h0);
        chk("restart_dpc",    decomp_pc_o, 32'h4);
        @(negedge clk);
        chk("restart_pc0", instr_pc_o, 32'h0);
        @(negedge clk);
        chk("restart_pc4", instr_pc_o, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
